// File: rtl/vga_pixel_pipe.sv
// Two-stage VGA pixel pipeline: fetches {R,G,B} from video RAM and re-times syncs to match.
// Define VGA_TEST_PATTERN_EN to build in an eight-bar colour test pattern selected by iTestPattern.
module vga_pixel_pipe #(
  parameter int X_WIDTH = 8,
  parameter int Y_WIDTH = 8,
  parameter int X_SIZE  = 256,
  parameter int Y_SIZE  = 256
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic [X_WIDTH-1:0]         iCol,
  input  logic [Y_WIDTH-1:0]         iRow,
  input  logic                       iDisplay,
  input  logic                       iHSync,
  input  logic                       iVSync,
  input  logic                       iTestPattern,
  output logic [X_WIDTH+Y_WIDTH-1:0] oMemAddr,
  output logic                       oMemReadEn,
  input  logic [2:0]                 iMemData,
  output logic                       oRed,
  output logic                       oGreen,
  output logic                       oBlue,
  output logic                       oHSync,
  output logic                       oVSync,
  output logic [7:0]                 oFrameCount
);

  typedef enum logic {STATE_SYNC_WAIT, STATE_RUN} state_t;

  state_t     state, state_next;
  logic       vsync_prev, vsync_fall;
  logic       s1_display, s1_hsync, s1_vsync;
  logic [2:0] pixel, rgb_next, rgb;
  logic       hsync_q, vsync_q;
  logic [7:0] frame_count;

  // Elaboration-time sanity checks on the geometry parameters.
  if ((X_SIZE & (X_SIZE - 1)) != 0 || X_SIZE > (1 << X_WIDTH)) begin : g_bad_x_size
    $error("X_SIZE must be a power of two that fits in X_WIDTH");
  end
  if (Y_SIZE < 1 || Y_SIZE > (1 << Y_WIDTH)) begin : g_bad_y_size
    $error("Y_SIZE must fit in Y_WIDTH");
  end

  // Falling edge: iVSync high at the previous edge, low at this one.
  assign vsync_fall = vsync_prev & ~iVSync;

  always_ff @(posedge Clock or negedge Reset)
    if (!Reset) state <= STATE_SYNC_WAIT;
    else        state <= state_next;

  always_comb begin
    state_next = state;
    if (state == STATE_SYNC_WAIT && vsync_fall) state_next = STATE_RUN;
  end

  // Stage 1: RAM address/strobe plus the control signals travelling with them.
  always_ff @(posedge Clock or negedge Reset)
    if (!Reset) begin
      oMemAddr   <= '0;
      oMemReadEn <= 1'b0;
      s1_display <= 1'b0;
      s1_hsync   <= 1'b1;
      s1_vsync   <= 1'b1;
      vsync_prev <= 1'b1;
    end else begin
      oMemAddr   <= {iRow, iCol};
      oMemReadEn <= iDisplay & (state == STATE_RUN);
      s1_display <= iDisplay;
      s1_hsync   <= iHSync;
      s1_vsync   <= iVSync;
      vsync_prev <= iVSync;
    end

`ifdef VGA_TEST_PATTERN_EN
  logic       s1_pattern;
  logic [2:0] s1_col_bar;

  // Only the top three column bits are needed: they pick one of eight bars.
  if (X_WIDTH < 3) begin : g_bad_x_width
    $error("test pattern needs X_WIDTH >= 3");
  end

  always_ff @(posedge Clock or negedge Reset)
    if (!Reset) begin
      s1_pattern <= 1'b0;
      s1_col_bar <= 3'b000;
    end else begin
      s1_pattern <= iTestPattern;
      s1_col_bar <= iCol[X_WIDTH-1:X_WIDTH-3];
    end

  always_comb begin
    pixel = iMemData;
    if (s1_pattern) pixel = s1_col_bar;
  end
`else
  logic unused_test_pattern;
  assign unused_test_pattern = iTestPattern;
  assign pixel = iMemData;
`endif

  assign rgb_next = (s1_display && state == STATE_RUN) ? pixel : 3'b000;

  // Stage 2: colour and syncs leave together, two clocks after the inputs.
  always_ff @(posedge Clock or negedge Reset)
    if (!Reset) begin
      rgb     <= 3'b000;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else begin
      rgb     <= rgb_next;
      hsync_q <= s1_hsync;
      vsync_q <= s1_vsync;
    end

  // The edge that starts RUN is not a completed frame, so it is not counted.
  always_ff @(posedge Clock or negedge Reset)
    if (!Reset)                                 frame_count <= 8'd0;
    else if (state == STATE_RUN && vsync_fall)  frame_count <= frame_count + 8'd1;

  assign oRed        = rgb[2];
  assign oGreen      = rgb[1];
  assign oBlue       = rgb[0];
  assign oHSync      = hsync_q;
  assign oVSync      = vsync_q;
  assign oFrameCount = frame_count;

endmodule

// File: tb/tb_vga_pixel_pipe.sv
// Self-checking bench for vga_pixel_pipe: reset/directed tables, sync/frame sequences, random traffic vs model.
module tb_vga_pixel_pipe;
  localparam int XW = 8;
  localparam int YW = 8;

  logic          Clock = 1'b0;
  logic          Reset = 1'b1;
  logic [XW-1:0] iCol;
  logic [YW-1:0] iRow;
  logic          iDisplay, iHSync, iVSync, iTestPattern;
  logic [XW+YW-1:0] oMemAddr;
  logic          oMemReadEn;
  logic [2:0]    iMemData;
  logic          oRed, oGreen, oBlue, oHSync, oVSync;
  logic [7:0]    oFrameCount;

  vga_pixel_pipe #(.X_WIDTH(XW), .Y_WIDTH(YW), .X_SIZE(256), .Y_SIZE(256)) dut (
    .Clock(Clock), .Reset(Reset), .iCol(iCol), .iRow(iRow), .iDisplay(iDisplay),
    .iHSync(iHSync), .iVSync(iVSync), .iTestPattern(iTestPattern),
    .oMemAddr(oMemAddr), .oMemReadEn(oMemReadEn), .iMemData(iMemData),
    .oRed(oRed), .oGreen(oGreen), .oBlue(oBlue), .oHSync(oHSync), .oVSync(oVSync),
    .oFrameCount(oFrameCount)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [7:0] row, col;
    logic       disp, hs, vs, tp;
    logic [2:0] mem;
  } in_t;

  typedef struct {
    in_t         in;
    logic [15:0] addr;
    logic        ren;
    logic [2:0]  rgb;
    logic        hs, vs;
    logic [7:0]  fc;
  } vec_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  in_t  prev;
  bit   run;
  int   fc;

  function automatic in_t mk(input logic [7:0] row, input logic [7:0] col, input logic disp,
                             input logic hs, input logic vs, input logic tp, input logic [2:0] mem);
    in_t v;
    v.row = row; v.col = col; v.disp = disp; v.hs = hs; v.vs = vs; v.tp = tp; v.mem = mem;
    return v;
  endfunction

  function automatic in_t rnd(input logic hs, input logic vs);
    return mk(8'($urandom), 8'($urandom), 1'($urandom), hs, vs, 1'($urandom), 3'($urandom));
  endfunction

  function automatic vec_t mkv(input in_t v, input logic [15:0] addr, input logic ren,
                               input logic [2:0] rgb, input logic hs, input logic vs, input logic [7:0] f);
    vec_t t;
    t.in = v; t.addr = addr; t.ren = ren; t.rgb = rgb; t.hs = hs; t.vs = vs; t.fc = f;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input in_t v);
    iRow = v.row; iCol = v.col; iDisplay = v.disp; iHSync = v.hs; iVSync = v.vs;
    iTestPattern = v.tp; iMemData = v.mem;
  endtask

  task automatic model_reset();
    prev = mk(8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 3'b000);
    run  = 1'b0;
    fc   = 0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_addr"},   32'(oMemAddr), 32'h0);
    chk({tag, "_ren"},    32'(oMemReadEn), 32'h0);
    chk({tag, "_rgb"},    32'({oRed, oGreen, oBlue}), 32'h0);
    chk({tag, "_hsync"},  32'(oHSync), 32'h1);
    chk({tag, "_vsync"},  32'(oVSync), 32'h1);
    chk({tag, "_fcount"}, 32'(oFrameCount), 32'h0);
  endtask

  // One clock: the model is stated in terms of "inputs at this edge" and "inputs one edge earlier".
  task automatic step(input in_t v);
    logic [2:0] src, exp_rgb;
    logic       fall, run_before;
    apply(v);
    @(posedge Clock); #1;
    fall       = prev.vs && !v.vs;
    run_before = run;
    src        = v.mem;
`ifdef VGA_TEST_PATTERN_EN
    if (prev.tp) src = prev.col[7:5];
`endif
    exp_rgb = (prev.disp && run_before) ? src : 3'b000;
    if (fall && run_before) fc = (fc + 1) % 256;
    if (fall) run = 1'b1;
    chk("mem_addr",    32'(oMemAddr), 32'({v.row, v.col}));
    chk("mem_read_en", 32'(oMemReadEn), 32'(v.disp && run_before));
    chk("colour",      32'({oRed, oGreen, oBlue}), 32'(exp_rgb));
    chk("hsync",       32'(oHSync), 32'(prev.hs));
    chk("vsync",       32'(oVSync), 32'(prev.vs));
    chk("frame_count", 32'(oFrameCount), 32'(fc));
    prev = v;
  endtask

  initial begin
    vec_t rst_tab[6];
    vec_t dir_tab[7];
    int   cnt, first;
    logic vs_r;

    // Inputs toggling under reset, including a vsync 1->0, must leave outputs at reset values.
    rst_tab[0] = mkv(mk(8'hFF, 8'hFF, 1, 0, 1, 1, 3'b111), 16'h0, 0, 3'b000, 1, 1, 8'd0);
    rst_tab[1] = mkv(mk(8'h12, 8'h34, 1, 1, 0, 0, 3'b101), 16'h0, 0, 3'b000, 1, 1, 8'd0);
    rst_tab[2] = mkv(mk(8'hA5, 8'h5A, 0, 0, 1, 1, 3'b010), 16'h0, 0, 3'b000, 1, 1, 8'd0);
    rst_tab[3] = mkv(mk(8'h00, 8'hE0, 1, 1, 0, 0, 3'b111), 16'h0, 0, 3'b000, 1, 1, 8'd0);
    rst_tab[4] = mkv(mk(8'h80, 8'h01, 1, 0, 1, 1, 3'b001), 16'h0, 0, 3'b000, 1, 1, 8'd0);
    rst_tab[5] = mkv(mk(8'h7F, 8'hFE, 1, 1, 1, 0, 3'b110), 16'h0, 0, 3'b000, 1, 1, 8'd0);

    // From release: three pixels before any vsync edge, the edge, then a fetched pixel.
    dir_tab[0] = mkv(mk(8'h12, 8'h34, 1, 1, 1, 0, 3'b101), 16'h1234, 0, 3'b000, 1, 1, 8'd0);
    dir_tab[1] = mkv(mk(8'h12, 8'h34, 1, 1, 1, 0, 3'b101), 16'h1234, 0, 3'b000, 1, 1, 8'd0);
    dir_tab[2] = mkv(mk(8'h12, 8'h34, 1, 1, 1, 0, 3'b101), 16'h1234, 0, 3'b000, 1, 1, 8'd0);
    dir_tab[3] = mkv(mk(8'h00, 8'h00, 0, 1, 0, 0, 3'b101), 16'h0000, 0, 3'b000, 1, 1, 8'd0);
    dir_tab[4] = mkv(mk(8'h12, 8'h34, 1, 1, 0, 0, 3'b000), 16'h1234, 1, 3'b000, 1, 0, 8'd0);
    dir_tab[5] = mkv(mk(8'h00, 8'h00, 0, 1, 0, 0, 3'b110), 16'h0000, 0, 3'b110, 1, 0, 8'd0);
    dir_tab[6] = mkv(mk(8'h56, 8'h78, 0, 1, 0, 0, 3'b111), 16'h5678, 0, 3'b000, 1, 0, 8'd0);

    apply(mk(8'h00, 8'h00, 0, 1, 1, 0, 3'b000));
    model_reset();
    #1 Reset = 1'b0;
    #1 chk_reset("por");

    for (int i = 0; i < 6; i++) begin
      apply(rst_tab[i].in);
      @(posedge Clock); #1;
      chk($sformatf("rst%0d_addr", i),  32'(oMemAddr), 32'(rst_tab[i].addr));
      chk($sformatf("rst%0d_ren", i),   32'(oMemReadEn), 32'(rst_tab[i].ren));
      chk($sformatf("rst%0d_rgb", i),   32'({oRed, oGreen, oBlue}), 32'(rst_tab[i].rgb));
      chk($sformatf("rst%0d_hsync", i), 32'(oHSync), 32'(rst_tab[i].hs));
      chk($sformatf("rst%0d_vsync", i), 32'(oVSync), 32'(rst_tab[i].vs));
      chk($sformatf("rst%0d_fc", i),    32'(oFrameCount), 32'(rst_tab[i].fc));
    end

    apply(mk(8'h00, 8'h00, 0, 1, 1, 0, 3'b000));
    Reset = 1'b1;
    model_reset();

    for (int i = 0; i < 7; i++) begin
      step(dir_tab[i].in);
      chk($sformatf("tab%0d_addr", i),  32'(oMemAddr), 32'(dir_tab[i].addr));
      chk($sformatf("tab%0d_ren", i),   32'(oMemReadEn), 32'(dir_tab[i].ren));
      chk($sformatf("tab%0d_rgb", i),   32'({oRed, oGreen, oBlue}), 32'(dir_tab[i].rgb));
      chk($sformatf("tab%0d_hsync", i), 32'(oHSync), 32'(dir_tab[i].hs));
      chk($sformatf("tab%0d_vsync", i), 32'(oVSync), 32'(dir_tab[i].vs));
      chk($sformatf("tab%0d_fc", i),    32'(oFrameCount), 32'(dir_tab[i].fc));
    end

    // 96-clock hsync pulse; a blanked pixel inside it must come out black.
    cnt = 0; first = -1;
    for (int i = 0; i < 100; i++) begin
      in_t v;
      v = rnd((i < 96) ? 1'b0 : 1'b1, 1'b0);
      v.tp = 1'b0;
      if (i == 9)  begin v.disp = 1'b1; end
      if (i == 10) begin v.disp = 1'b0; v.mem = 3'b111; end
      if (i == 11) v.mem = 3'b111;
      step(v);
      if (i == 11) chk("blank_aligned", 32'({oRed, oGreen, oBlue}), 32'h0);
      if (oHSync == 1'b0) begin
        cnt++;
        if (first < 0) first = i;
      end
    end
    chk("hsync_width", 32'(cnt), 32'd96);
    chk("hsync_delay", 32'(first), 32'd1);

    // 257 further vsync falling edges: the counter wraps through zero to one.
    for (int f = 1; f <= 257; f++) begin
      step(rnd(1'($urandom), 1'b1));
      step(rnd(1'($urandom), 1'b1));
      step(rnd(1'($urandom), 1'b0));
      step(rnd(1'($urandom), 1'b0));
      if (f == 255 || f == 256 || f == 257)
        chk($sformatf("fcount_after_%0d", f), 32'(oFrameCount), 32'(f % 256));
    end

    vs_r = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(15) == 0) vs_r = ~vs_r;
      step(rnd(1'($urandom), vs_r));
    end

`ifdef VGA_TEST_PATTERN_EN
    step(mk(8'h00, 8'hE0, 1, 1, 0, 1, 3'b000));
    step(mk(8'h00, 8'h20, 1, 1, 0, 1, 3'b010));
    chk("bar_e0", 32'({oRed, oGreen, oBlue}), 32'h7);
    step(mk(8'h00, 8'h00, 1, 1, 0, 0, 3'b000));
    chk("bar_20", 32'({oRed, oGreen, oBlue}), 32'h1);
`endif

    // Reset mid-line: outputs must drop without waiting for a clock edge.
    step(mk(8'h40, 8'h10, 1, 1, 0, 0, 3'b111));
    step(mk(8'h40, 8'h11, 1, 1, 0, 0, 3'b111));
    chk("pre_reset_colour", 32'({oRed, oGreen, oBlue}), 32'h7);
    #2 Reset = 1'b0;
    #1 chk_reset("midline");
    model_reset();
    apply(mk(8'h00, 8'h00, 0, 1, 1, 0, 3'b000));
    @(posedge Clock); #1;
    Reset = 1'b1;

    // Pixels after release stay dark until a fresh vsync falling edge.
    for (int i = 0; i < 4; i++) step(mk(8'h01, 8'(i), 1, 1, 1, 0, 3'b111));
    chk("post_reset_dark", 32'({oRed, oGreen, oBlue}), 32'h0);
    step(mk(8'h01, 8'h05, 1, 1, 0, 0, 3'b111));
    step(mk(8'h01, 8'h06, 1, 1, 0, 0, 3'b011));
    chk("post_reset_lit", 32'({oRed, oGreen, oBlue}), 32'h3);
    step(mk(8'h01, 8'h07, 0, 1, 0, 0, 3'b000));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_pixel_pipe.md
VGA_PIXEL_PIPE -- requirements
Module: vga_pixel_pipe

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- X_WIDTH, 8, column index width.
- Y_WIDTH, 8, row index width.
- X_SIZE, 256, visible columns; power of two.
- Y_SIZE, 256, visible rows.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- Clock  in  1  single clock for all logic.
- Reset  in  1  asynchronous, active-low reset.
- iCol  in  X_WIDTH  column from the VGA controller.
- iRow  in  Y_WIDTH  row from the VGA controller.
- iDisplay  in  1  active-video flag from the controller.
- iHSync  in  1  horizontal sync from the controller.
- iVSync  in  1  vertical sync from the controller.
- iTestPattern  in  1  selects colour bars; ignored when VGA_TEST_PATTERN_EN is undefined.
- oMemAddr  out  X_WIDTH+Y_WIDTH  video RAM read address.
- oMemReadEn  out  1  video RAM read strobe.
- iMemData  in  3  RAM pixel {R,G,B}; valid the cycle after oMemReadEn is high.
- oRed, oGreen, oBlue  out  1 each  pixel colour to the DAC pins.
- oHSync, oVSync  out  1 each  delayed syncs, aligned with the colour outputs.
- oFrameCount  out  8  completed-frame counter.

Function
REQ-003 The FSM SHALL have two states: STATE_SYNC_WAIT (entered on reset) and STATE_RUN.
REQ-004 STATE_SYNC_WAIT SHALL go to STATE_RUN on the first iVSync falling edge (iVSync sampled 1, then 0 on the next edge); STATE_RUN SHALL be left only by reset.
REQ-005 oMemAddr SHALL be registered as {iRow, iCol} at every clock edge.
REQ-006 oMemReadEn SHALL be registered as iDisplay AND (state == STATE_RUN).
REQ-007 Stage 1 SHALL register iDisplay, iHSync, iVSync and iCol alongside oMemAddr.
REQ-008 Stage 2 SHALL register:
- the colour outputs from iMemData when stage-1 display is 1 and state is STATE_RUN, else 0;
- oHSync and oVSync from stage 1.
REQ-009 Latency from any input to the matching colour and sync outputs SHALL be exactly 2 clocks, identical for all signals.
REQ-010 Colour outputs SHALL be 0 whenever the delayed display flag is 0, with no exceptions.
REQ-011 oFrameCount SHALL increment by 1 on each stage-1 iVSync falling edge while in STATE_RUN, and SHALL wrap from 255 to 0.
REQ-012 The falling edge that causes STATE_SYNC_WAIT -> STATE_RUN SHALL NOT increment oFrameCount.
REQ-013 iRow/iCol values of X_SIZE or above, or Y_SIZE or above, SHALL be passed to oMemAddr unmodified, with no clamping.
REQ-014 Sync and colour outputs SHALL have no combinational path from any input.

Reset
REQ-015 While Reset = 0, these outputs SHALL be held:
- oMemAddr = 0, oMemReadEn = 0, colour outputs = 0, oFrameCount = 0;
- oHSync = 1, oVSync = 1;
- all stage-1 registers cleared, with syncs = 1;
- state = STATE_SYNC_WAIT, vsync edge register = 1.
REQ-016 Reset assertion mid-frame SHALL force these values immediately, without waiting for a clock edge.
REQ-017 After reset release, the block SHALL wait for a new iVSync falling edge before showing pixels.

Configuration
REQ-018 With macro VGA_TEST_PATTERN_EN defined and iTestPattern = 1:
- stage 2 SHALL register colour = stage-1 iCol[X_WIDTH-1:X_WIDTH-3] in place of iMemData, giving eight vertical bars;
- blanking and latency rules SHALL be unchanged.
REQ-019 With VGA_TEST_PATTERN_EN undefined:
- iTestPattern SHALL be ignored;
- the block SHALL contain no pattern logic;
- colour SHALL always come from iMemData.

Verification
REQ-020 Reset low, inputs toggling -> all outputs at reset values; iVSync 1->0 with Reset low does not leave STATE_SYNC_WAIT.
REQ-021 After release, iDisplay = 1 and iMemData = 3'b101 before any vsync edge -> colour stays 000 and oMemReadEn stays 0.
REQ-022 vsync edge, then iRow = 8'h12, iCol = 8'h34, iDisplay = 1 -> oMemAddr = 16'h1234 and oMemReadEn = 1 one clock later; iMemData = 3'b110 gives colour 110 two clocks after the input.
REQ-023 iHSync pulse 96 clocks wide -> oHSync pulse 96 clocks wide, delayed exactly 2 clocks; iDisplay = 0 forces colour 000 at the aligned cycle.
REQ-024 257 vsync falling edges after the first -> oFrameCount = 1 (wrap 255 -> 0 checked).
REQ-025 VGA_TEST_PATTERN_EN defined, iTestPattern = 1, iCol = 8'hE0 -> colour 111; iCol = 8'h20 -> colour 001; Reset asserted mid-line -> colour 000 immediately.
